// File: rtl/y_seq_arith_pkg.sv
// Shared op codes and FSM state encoding for the sequential arithmetic unit.
package y_arith_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/y_seq_arith_add_sub.sv
// Combinational WIDTH-bit adder/subtractor: sum = a + (sub ? ~b + 1 : b),
// with carry-out and signed overflow of the effective addition.
module y_add_sub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   logic [WIDTH-1:0] w_b_eff;

   assign w_b_eff         = i_sub ? ~i_b : i_b;
   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
   assign o_ovf           = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/y_seq_arith.sv
// Handshaked multi-cycle ADD/SUB/SLT/MUL unit. The radix-2 shift-add multiplier
// is built only when Y_SEQ_ARITH_MUL_EN is defined; otherwise MUL reports err.
module y_seq_arith
   import y_arith_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] z_hi,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_z;
   logic [WIDTH-1:0] r_z_hi;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_err;

   logic             w_accept;
   logic             w_is_sub;
   logic [WIDTH-1:0] w_alu_sum;
   logic             w_alu_cout;
   logic             w_alu_ovf;
   logic             w_slt;

   assign w_accept = in_valid && in_ready;
   assign w_is_sub = (op == OP_SUB) || (op == OP_SLT);
   // Signed less-than: sign of a-b corrected by overflow.
   assign w_slt    = w_alu_sum[WIDTH-1] ^ w_alu_ovf;

   y_add_sub #(.WIDTH(WIDTH)) u_alu (
      .i_a    (a),
      .i_b    (b),
      .i_sub  (w_is_sub),
      .o_sum  (w_alu_sum),
      .o_cout (w_alu_cout),
      .o_ovf  (w_alu_ovf)
   );

`ifdef Y_SEQ_ARITH_MUL_EN
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mcand;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_mac_sum;
   logic               w_mac_cout;
   logic               w_mac_ovf_unused;
   logic [2*WIDTH-1:0] w_prod_step;

   assign w_addend    = r_prod[0] ? r_mcand : '0;
   // Accumulate into the high half, then shift {carry, product} right by one.
   assign w_prod_step = {w_mac_cout, w_mac_sum, r_prod[WIDTH-1:1]};

   y_add_sub #(.WIDTH(WIDTH)) u_mac (
      .i_a    (r_prod[2*WIDTH-1:WIDTH]),
      .i_b    (w_addend),
      .i_sub  (1'b0),
      .o_sum  (w_mac_sum),
      .o_cout (w_mac_cout),
      .o_ovf  (w_mac_ovf_unused)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef Y_SEQ_ARITH_MUL_EN
               w_state_next = (op == OP_MUL) ? ST_BUSY : ST_DONE;
`else
               w_state_next = ST_DONE;
`endif
            end
         end
`ifdef Y_SEQ_ARITH_MUL_EN
         ST_BUSY: if (r_cnt == CNT_W'(1)) w_state_next = ST_DONE;
`endif
         ST_DONE: if (out_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
   end

   // Result registers only change on accept or on the last multiply step,
   // so they stay stable through DONE and after the handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z    <= '0;
         r_z_hi <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
         r_err  <= 1'b0;
`ifdef Y_SEQ_ARITH_MUL_EN
         r_prod  <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
`endif
      end else if (w_accept) begin
         r_err  <= 1'b0;
         r_z_hi <= '0;
         case (op)
            OP_ADD, OP_SUB: begin
               r_z    <= w_alu_sum;
               r_cout <= w_alu_cout;
               r_ovf  <= w_alu_ovf;
               r_zero <= (w_alu_sum == '0);
            end
            OP_SLT: begin
               r_z    <= {{(WIDTH-1){1'b0}}, w_slt};
               r_cout <= 1'b0;
               r_ovf  <= 1'b0;
               r_zero <= ~w_slt;
            end
            default: begin
`ifdef Y_SEQ_ARITH_MUL_EN
               r_prod  <= {{WIDTH{1'b0}}, b};
               r_mcand <= a;
               r_cnt   <= CNT_W'(WIDTH);
`else
               r_z    <= '0;
               r_cout <= 1'b0;
               r_ovf  <= 1'b0;
               r_zero <= 1'b1;
               r_err  <= 1'b1;
`endif
            end
         endcase
`ifdef Y_SEQ_ARITH_MUL_EN
      end else if (r_state == ST_BUSY) begin
         r_prod <= w_prod_step;
         r_cnt  <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_z    <= w_prod_step[WIDTH-1:0];
            r_z_hi <= w_prod_step[2*WIDTH-1:WIDTH];
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= (w_prod_step[WIDTH-1:0] == '0);
         end
`endif
      end
   end

   assign z    = r_z;
   assign z_hi = r_z_hi;
   assign cout = r_cout;
   assign ovf  = r_ovf;
   assign zero = r_zero;
   assign err  = r_err;

endmodule

// File: tb/tb_y_seq_arith.sv
// Self-checking bench for y_seq_arith (WIDTH=32): directed scenarios plus
// 1000 random ops against an arithmetic reference model.
module tb_y_seq_arith;

   localparam logic [1:0] T_ADD = 2'b00;
   localparam logic [1:0] T_SUB = 2'b01;
   localparam logic [1:0] T_MUL = 2'b10;
   localparam logic [1:0] T_SLT = 2'b11;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] z;
   logic [31:0] z_hi;
   logic        cout;
   logic        ovf;
   logic        zero;
   logic        err;

   int total = 0;
   int bad   = 0;

   y_seq_arith #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .z_hi      (z_hi),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model from the arithmetic definitions.
   task automatic model(input logic [1:0] m_op, input logic [31:0] ma, input logic [31:0] mb,
                        output logic [31:0] ez, output logic [31:0] ezh, output logic ec,
                        output logic ev, output logic ezr, output logic ee, output int elat);
      longint sa, sb, sr;
      logic [63:0] u;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      ez = 32'd0; ezh = 32'd0; ec = 1'b0; ev = 1'b0; ee = 1'b0; elat = 1;
      case (m_op)
         T_ADD: begin
            u  = 64'(ma) + 64'(mb);
            ez = u[31:0];
            ec = u[32];
            sr = sa + sb;
            ev = (sr > SMAX) || (sr < SMIN);
         end
         T_SUB: begin
            ez = ma - mb;
            ec = (ma >= mb);
            sr = sa - sb;
            ev = (sr > SMAX) || (sr < SMIN);
         end
         T_SLT: ez = (sa < sb) ? 32'd1 : 32'd0;
         default: begin
`ifdef Y_SEQ_ARITH_MUL_EN
            u    = 64'(ma) * 64'(mb);
            ez   = u[31:0];
            ezh  = u[63:32];
            elat = 33;
`else
            ee = 1'b1;
`endif
         end
      endcase
      ezr = (ez == 32'd0);
   endtask

   // Drives one request, waits for the result, holds it `hold` cycles, hands it off.
   task automatic xact(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                       input int hold, output logic [31:0] o_z, output logic [31:0] o_zh,
                       output logic o_c, output logic o_v, output logic o_zr, output logic o_e,
                       output int lat, output logic rdy_busy);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      lat = 1;
      rdy_busy = 1'b0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         rdy_busy = rdy_busy | in_ready;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!out_valid) lat = -1;
      repeat (hold) @(negedge clk);
      o_z = z; o_zh = z_hi; o_c = cout; o_v = ovf; o_zr = zero; o_e = err;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      $display("xact op=%0d a=%h b=%h -> z=%h z_hi=%h cout=%0b ovf=%0b zero=%0b err=%0b lat=%0d",
               t_op, t_a, t_b, o_z, o_zh, o_c, o_v, o_zr, o_e, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1; op = T_ADD; a = 32'd1; b = 32'd2;
      repeat (3) @(negedge clk);
      total++;
      if ({out_valid, z, z_hi, cout, ovf, zero, err} !== 68'd0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%0b z=%h z_hi=%h c=%0b v=%0b zero=%0b err=%0b, need all 0",
                  out_valid, z, z_hi, cout, ovf, zero, err);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %0b need 1", in_ready);
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_accept: out_valid got %0b need 0", out_valid);
      end
      $display("xact reset released");
   endtask

   task automatic test_add();
      logic [31:0] rz, rzh; logic rc, rv, rzr, re, rb; int lat;
      xact(T_ADD, 32'hFFFFFFFF, 32'h1, 0, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if ({rz, rzh, rc, rv, rzr, re} !== {32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0} || lat !== 1) begin
         bad++;
         $display("FAIL add_wrap: got z=%h zh=%h c=%0b v=%0b zero=%0b err=%0b lat=%0d, need z=0 zh=0 c=1 v=0 zero=1 err=0 lat=1",
                  rz, rzh, rc, rv, rzr, re, lat);
      end
   endtask

   task automatic test_sub();
      logic [31:0] rz, rzh; logic rc, rv, rzr, re, rb; int lat;
      xact(T_SUB, 32'd5, 32'd7, 0, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if ({rz, rc, rv, rzr} !== {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0} || lat !== 1) begin
         bad++;
         $display("FAIL sub_neg: got z=%h c=%0b v=%0b zero=%0b lat=%0d, need z=fffffffe c=0 v=0 zero=0 lat=1",
                  rz, rc, rv, rzr, lat);
      end
      xact(T_SUB, 32'h80000000, 32'd1, 0, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if ({rz, rc, rv} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL sub_ovf: got z=%h c=%0b v=%0b, need z=7fffffff c=1 v=1", rz, rc, rv);
      end
   endtask

   task automatic test_mul();
      logic [31:0] rz, rzh; logic rc, rv, rzr, re, rb; int lat;
`ifdef Y_SEQ_ARITH_MUL_EN
      xact(T_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if ({rzh, rz, rc, rv, rzr, re} !== {32'hFFFFFFFE, 32'h1, 4'b0000} || lat !== 33) begin
         bad++;
         $display("FAIL mul_max: got zh=%h z=%h c=%0b v=%0b zero=%0b err=%0b lat=%0d, need zh=fffffffe z=1 flags 0 lat=33",
                  rzh, rz, rc, rv, rzr, re, lat);
      end
      total++;
      if (rb !== 1'b0) begin
         bad++;
         $display("FAIL mul_busy_ready: in_ready seen %0b while busy, need 0", rb);
      end
      xact(T_MUL, 32'h12345678, 32'h0, 1, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if ({rzh, rz, rzr} !== {64'h0, 1'b1} || lat !== 33) begin
         bad++;
         $display("FAIL mul_zero: got zh=%h z=%h zero=%0b lat=%0d, need 0 0 1 lat=33", rzh, rz, rzr, lat);
      end
`else
      xact(T_MUL, 32'd3, 32'd4, 0, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if ({rz, rzh, rc, rv, rzr, re} !== {64'h0, 4'b0011} || lat !== 1) begin
         bad++;
         $display("FAIL mul_disabled: got z=%h zh=%h c=%0b v=%0b zero=%0b err=%0b lat=%0d, need 0 0 0 0 1 1 lat=1",
                  rz, rzh, rc, rv, rzr, re, lat);
      end
`endif
   endtask

   task automatic test_slt();
      logic [31:0] rz, rzh; logic rc, rv, rzr, re, rb; int lat;
      logic [31:0] sa [3] = '{32'hFFFFFFFF, 32'h1, 32'h80000000};
      logic [31:0] sb [3] = '{32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF};
      logic [31:0] sz [3] = '{32'd1, 32'd0, 32'd1};
      for (int i = 0; i < 3; i++) begin
         xact(T_SLT, sa[i], sb[i], 0, rz, rzh, rc, rv, rzr, re, lat, rb);
         total++;
         if ({rz, rc, rv, rzr} !== {sz[i], 1'b0, 1'b0, (sz[i] == 32'd0)} || lat !== 1) begin
            bad++;
            $display("FAIL slt_%0d: got z=%h c=%0b v=%0b zero=%0b lat=%0d, need z=%h c=0 v=0 lat=1",
                     i, rz, rc, rv, rzr, lat, sz[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      op = T_ADD; a = 32'd2; b = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      op = T_ADD; a = 32'd100; b = 32'd200;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || z !== 32'd5 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_%0d: got valid=%0b z=%h in_ready=%0b, need valid=1 z=5 in_ready=0",
                     i, out_valid, z, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== 32'd5) begin
         bad++;
         $display("FAIL bp_handoff: got valid=%0b in_ready=%0b z=%h, need valid=0 in_ready=1 z=5 held",
                  out_valid, in_ready, z);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_no_second: out_valid got %0b need 0", out_valid);
      end
      $display("xact backpressure add 2+3 z=%h", z);
   endtask

   task automatic test_reset_abort();
      logic [31:0] rz, rzh; logic rc, rv, rzr, re, rb; int lat;
      @(negedge clk);
`ifdef Y_SEQ_ARITH_MUL_EN
      op = T_MUL; a = 32'h0000FFFF; b = 32'h00012345;
`else
      op = T_ADD; a = 32'd7; b = 32'd8;
`endif
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
`ifdef Y_SEQ_ARITH_MUL_EN
      repeat (9) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort_busy: got valid=%0b in_ready=%0b, need 0 0", out_valid, in_ready);
      end
`endif
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, z, z_hi, cout, ovf, zero, err} !== 68'd0) begin
         bad++;
         $display("FAIL abort_clear: got valid=%0b z=%h z_hi=%h c=%0b v=%0b zero=%0b err=%0b, need all 0",
                  out_valid, z, z_hi, cout, ovf, zero, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL abort_resume: got valid=%0b in_ready=%0b, need 0 1", out_valid, in_ready);
      end
      xact(T_ADD, 32'd2, 32'd3, 0, rz, rzh, rc, rv, rzr, re, lat, rb);
      total++;
      if (rz !== 32'd5 || lat !== 1) begin
         bad++;
         $display("FAIL abort_then_add: got z=%h lat=%0d, need z=5 lat=1", rz, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] rz, rzh, ez, ezh, ra, rbv; logic rc, rv, rzr, re, rb, ec, ev, ezr, ee;
      logic [1:0] rop;
      int lat, elat;
      logic [31:0] corner [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
      for (int n = 0; n < 1000; n++) begin
         rop = 2'($urandom);
         ra  = ($urandom_range(0, 7) < 2) ? corner[$urandom_range(0, 4)] : $urandom;
         rbv = ($urandom_range(0, 7) < 2) ? corner[$urandom_range(0, 4)] : $urandom;
         model(rop, ra, rbv, ez, ezh, ec, ev, ezr, ee, elat);
         xact(rop, ra, rbv, $urandom_range(0, 2), rz, rzh, rc, rv, rzr, re, lat, rb);
         total++;
         if ({rz, rzh, rc, rv, rzr, re} !== {ez, ezh, ec, ev, ezr, ee} || lat !== elat) begin
            bad++;
            $display("FAIL rand_%0d op=%0d a=%h b=%h: got z=%h zh=%h c=%0b v=%0b zero=%0b err=%0b lat=%0d, need z=%h zh=%h c=%0b v=%0b zero=%0b err=%0b lat=%0d",
                     n, rop, ra, rbv, rz, rzh, rc, rv, rzr, re, lat, ez, ezh, ec, ev, ezr, ee, elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_slt();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
